// File: rtl/vga_seq_pkg.sv
// Shared state type, cfg_mode encodings and wrap constants for the VGA frame sequencer.
package vga_seq_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_AUTO   = 3'd1,
        S_MANUAL = 3'd2,
        S_FREEZE = 3'd3,
        S_BLANK  = 3'd4
    } seq_state_t;

    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_MANUAL = 2'b01;
    localparam logic [1:0] MODE_FREEZE = 2'b10;
    localparam logic [1:0] MODE_BLANK  = 2'b11;

    localparam int SCROLL_WRAP  = 1024;
    localparam int VSCROLL_WRAP = 480;

    function automatic seq_state_t mode_to_state(input logic [1:0] mode);
        case (mode)
            MODE_AUTO:   return S_AUTO;
            MODE_MANUAL: return S_MANUAL;
            MODE_FREEZE: return S_FREEZE;
            default:     return S_BLANK;
        endcase
    endfunction

    // Modular add for the scroll offsets; the step is always below the wrap value.
    function automatic logic [9:0] wrap_add(input logic [9:0] value, input logic [9:0] step,
                                            input int wrap);
        int sum;
        sum = int'(value) + int'(step);
        if (sum >= wrap) begin
            sum = sum - wrap;
        end
        return 10'(sum);
    endfunction

endpackage

// File: rtl/vga_btn_pending.sv
// Button synchronizer, rising-edge detect and per-frame pending flag for the frame sequencer.
module vga_btn_pending
    import vga_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic tick,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   last;
    logic                   pending;
    logic                   rise;

    assign rise  = sync[SYNC_STAGES-1] & ~last;
    // An edge arriving in the tick cycle itself counts toward that tick.
    assign press = pending | rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            last    <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
            last <= sync[SYNC_STAGES-1];
            if (tick) begin
                pending <= 1'b0;
            end else if (rise) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_frame_sequencer.sv
// Frame-rate pattern/scroll/blank scheduler for the TinyVGA datapath; outputs change only on frame ticks.
// Define VGA_SEQ_VSCROLL_EN to add a vertical scroll register on scroll_y (otherwise scroll_y is 0).
module vga_frame_sequencer
    import vga_seq_pkg::*;
#(
    parameter int NUM_PATTERNS = 6,
    parameter int DWELL_FRAMES = 120,
    parameter int SCROLL_STEP  = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic [1:0] cfg_mode,
    input  logic [3:0] cfg_sel,
    input  logic       btn_next,
    output logic [2:0] pattern_sel,
    output logic [9:0] scroll_x,
    output logic [9:0] scroll_y,
    output logic       blank,
    output logic       frame_tick,
    output logic [7:0] frame_cnt
);

    localparam int                  DWELL_W      = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [DWELL_W-1:0]  DWELL_LAST   = DWELL_W'(DWELL_FRAMES - 1);
    localparam logic [2:0]          LAST_PATTERN = 3'(NUM_PATTERNS - 1);
    localparam logic [3:0]          LAST_SEL     = 4'(NUM_PATTERNS - 1);
    localparam logic [9:0]          STEP         = 10'(SCROLL_STEP);

    seq_state_t         state;
    seq_state_t         state_nxt;
    logic               vsync_q;
    logic               tick;
    logic               press;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_nxt;
    logic [DWELL_W-1:0] dwell_base;
    logic [2:0]         pattern_nxt;
    logic [2:0]         pattern_adv;
    logic [2:0]         manual_sel;
    logic [9:0]         scroll_x_nxt;
    logic               blank_nxt;
`ifdef VGA_SEQ_VSCROLL_EN
    logic [9:0]         scroll_y_q;
    logic [9:0]         scroll_y_nxt;
`endif

    assign tick        = vsync & ~vsync_q;
    assign pattern_adv = (pattern_sel == LAST_PATTERN) ? 3'd0 : pattern_sel + 3'd1;
    assign manual_sel  = (cfg_sel > LAST_SEL) ? LAST_PATTERN : cfg_sel[2:0];

`ifdef VGA_SEQ_VSCROLL_EN
    assign scroll_y = scroll_y_q;
`else
    assign scroll_y = 10'd0;
`endif

    vga_btn_pending #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_btn (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_next),
        .tick (tick),
        .press(press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (tick) begin
            state_nxt = mode_to_state(cfg_mode);
        end
    end

    // Actions belong to the state being entered, so they key off state_nxt.
    always_comb begin
        pattern_nxt  = pattern_sel;
        scroll_x_nxt = scroll_x;
        blank_nxt    = blank;
        dwell_nxt    = dwell;
        dwell_base   = (state == S_AUTO) ? dwell : '0;
`ifdef VGA_SEQ_VSCROLL_EN
        scroll_y_nxt = scroll_y_q;
`endif
        if (tick) begin
            case (state_nxt)
                S_AUTO: begin
                    blank_nxt    = 1'b0;
                    scroll_x_nxt = wrap_add(scroll_x, STEP, SCROLL_WRAP);
                    if (press || dwell_base == DWELL_LAST) begin
                        dwell_nxt   = '0;
                        pattern_nxt = pattern_adv;
                    end else begin
                        dwell_nxt = dwell_base + DWELL_W'(1);
                    end
`ifdef VGA_SEQ_VSCROLL_EN
                    scroll_y_nxt = wrap_add(scroll_y_q, 10'd1, VSCROLL_WRAP);
`endif
                end
                S_MANUAL: begin
                    blank_nxt    = 1'b0;
                    scroll_x_nxt = wrap_add(scroll_x, STEP, SCROLL_WRAP);
                    pattern_nxt  = manual_sel;
                    dwell_nxt    = '0;
`ifdef VGA_SEQ_VSCROLL_EN
                    scroll_y_nxt = wrap_add(scroll_y_q, 10'd1, VSCROLL_WRAP);
`endif
                end
                S_FREEZE: begin
                    blank_nxt = 1'b0;
                    if (press) begin
                        pattern_nxt = pattern_adv;
                    end
                end
                S_BLANK: begin
                    blank_nxt = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            frame_tick  <= 1'b0;
            frame_cnt   <= 8'd0;
            pattern_sel <= 3'd0;
            scroll_x    <= 10'd0;
            blank       <= 1'b1;
            dwell       <= '0;
`ifdef VGA_SEQ_VSCROLL_EN
            scroll_y_q  <= 10'd0;
`endif
        end else begin
            vsync_q     <= vsync;
            frame_tick  <= tick;
            pattern_sel <= pattern_nxt;
            scroll_x    <= scroll_x_nxt;
            blank       <= blank_nxt;
            dwell       <= dwell_nxt;
`ifdef VGA_SEQ_VSCROLL_EN
            scroll_y_q  <= scroll_y_nxt;
`endif
            if (tick) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Randomized self-checking bench for vga_frame_sequencer against a frame-level reference model.
// Honors VGA_SEQ_VSCROLL_EN the same way as the design.
module tb_vga_frame_sequencer;

    localparam int NUM_PATTERNS = 6;
    localparam int DWELL_FRAMES = 3;
    localparam int SCROLL_STEP  = 1000;
    localparam int SYNC_STAGES  = 2;
`ifdef VGA_SEQ_VSCROLL_EN
    localparam bit VSCROLL = 1'b1;
`else
    localparam bit VSCROLL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_sel;
    logic       btn_next;
    logic [2:0] pattern_sel;
    logic [9:0] scroll_x;
    logic [9:0] scroll_y;
    logic       blank;
    logic       frame_tick;
    logic [7:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: mode number of the current state (-1 while waiting for the first frame).
    int m_state;
    int m_pat;
    int m_sx;
    int m_sy;
    int m_blank;
    int m_frame;
    int m_dwell;

    int exp_auto [10] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3};

    always #5 clk = ~clk;

    vga_frame_sequencer #(
        .NUM_PATTERNS(NUM_PATTERNS),
        .DWELL_FRAMES(DWELL_FRAMES),
        .SCROLL_STEP (SCROLL_STEP),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .cfg_mode   (cfg_mode),
        .cfg_sel    (cfg_sel),
        .btn_next   (btn_next),
        .pattern_sel(pattern_sel),
        .scroll_x   (scroll_x),
        .scroll_y   (scroll_y),
        .blank      (blank),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkFrame(input string tag, input int exp_tick);
        checkOutput({tag, ".pattern_sel"}, int'(pattern_sel), m_pat);
        checkOutput({tag, ".scroll_x"}, int'(scroll_x), m_sx);
        checkOutput({tag, ".scroll_y"}, int'(scroll_y), m_sy);
        checkOutput({tag, ".blank"}, int'(blank), m_blank);
        checkOutput({tag, ".frame_cnt"}, int'(frame_cnt), m_frame);
        checkOutput({tag, ".frame_tick"}, int'(frame_tick), exp_tick);
    endtask

    task automatic modelReset();
        m_state = -1;
        m_pat   = 0;
        m_sx    = 0;
        m_sy    = 0;
        m_blank = 1;
        m_frame = 0;
        m_dwell = 0;
    endtask

    // One frame boundary seen by the model: mode and selector as sampled at the tick.
    task automatic modelTick(input int mode, input int sel, input bit pressed);
        int d;
        m_frame = (m_frame + 1) % 256;
        case (mode)
            0: begin
                m_blank = 0;
                m_sx    = (m_sx + SCROLL_STEP) % 1024;
                d       = (m_state == 0) ? m_dwell : 0;
                if (pressed || d == DWELL_FRAMES - 1) begin
                    m_dwell = 0;
                    m_pat   = (m_pat + 1) % NUM_PATTERNS;
                end else begin
                    m_dwell = d + 1;
                end
                if (VSCROLL) m_sy = (m_sy + 1) % 480;
            end
            1: begin
                m_blank = 0;
                m_sx    = (m_sx + SCROLL_STEP) % 1024;
                m_pat   = (sel > NUM_PATTERNS - 1) ? NUM_PATTERNS - 1 : sel;
                m_dwell = 0;
                if (VSCROLL) m_sy = (m_sy + 1) % 480;
            end
            2: begin
                m_blank = 0;
                if (pressed) m_pat = (m_pat + 1) % NUM_PATTERNS;
            end
            default: begin
                m_blank = 1;
            end
        endcase
        m_state = mode;
    endtask

    // One full frame: cfg noise and button presses mid-frame, final cfg, then a vsync rising edge.
    task automatic applyStimulus(input int mode, input int sel, input int presses);
        @(negedge clk);
        vsync    = 1'b0;
        cfg_mode = 2'($urandom);
        cfg_sel  = 4'($urandom);
        repeat (2) @(negedge clk);
        checkFrame("hold", 0);
        for (int p = 0; p < presses; p++) begin
            btn_next = 1'b1;
            repeat (2) @(negedge clk);
            btn_next = 1'b0;
            repeat (2) @(negedge clk);
        end
        cfg_mode = 2'(mode);
        cfg_sel  = 4'(sel);
        repeat (SYNC_STAGES + 4) @(negedge clk);
        checkFrame("prevsync", 0);
        vsync = 1'b1;
        modelTick(mode, sel, presses > 0);
        @(negedge clk);
        checkFrame("tick", 1);
        @(negedge clk);
        checkOutput("tick_width", int'(frame_tick), 0);
    endtask

    task automatic resetMidFrame();
        @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkFrame("async_reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b1;
        vsync    = 1'b0;
        cfg_mode = 2'b00;
        cfg_sel  = 4'd0;
        btn_next = 1'b0;
        modelReset();
        #3;
        rst_n = 1'b0;
        #1;
        checkFrame("reset", 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkFrame("wait_state", 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0);
            checkOutput("auto_seq", int'(pattern_sel), exp_auto[i]);
        end
        checkOutput("auto_scroll10", int'(scroll_x), 784);
        checkOutput("auto_frames10", int'(frame_cnt), 10);

        applyStimulus(0, 0, 3);
        checkOutput("auto_btn_once", int'(pattern_sel), 4);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("auto_dwell_restart", int'(pattern_sel), 4);
        applyStimulus(0, 0, 0);
        checkOutput("auto_dwell_expire", int'(pattern_sel), 5);

        applyStimulus(1, 9, 2);
        checkOutput("manual_clamp", int'(pattern_sel), 5);
        applyStimulus(1, 4, 0);
        checkOutput("manual_sel", int'(pattern_sel), 4);

        applyStimulus(2, 0, 0);
        applyStimulus(2, 0, 1);
        checkOutput("freeze_adv1", int'(pattern_sel), 5);
        applyStimulus(2, 0, 2);
        checkOutput("freeze_wrap", int'(pattern_sel), 0);
        applyStimulus(2, 0, 0);
        applyStimulus(2, 0, 0);
        applyStimulus(3, 0, 1);
        checkOutput("blank_on", int'(blank), 1);
        applyStimulus(3, 0, 0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3));
        end

        resetMidFrame();
        cfg_mode = 2'b01;
        cfg_sel  = 4'd2;
        for (int i = 0; i < 481; i++) begin
            @(negedge clk);
            vsync = 1'b1;
            modelTick(1, 2, 1'b0);
            @(negedge clk);
            vsync = 1'b0;
        end
        @(negedge clk);
        checkFrame("long_run", 0);
        checkOutput("vscroll_481", int'(scroll_y), VSCROLL ? 1 : 0);
        checkOutput("frame_wrap", int'(frame_cnt), 225);

        for (int i = 0; i < 15; i++) begin
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
